m8088_bus_target: RTL and testbench

M8088_BUS_TARGET -- requirements
Module: m8088_bus_target

---
 rtl/m8088_bus_pkg.sv | 16 +
 rtl/m8088_wait_counter.sv | 27 ++
 rtl/m8088_bus_target.sv | 174 +++++++++++++++++
 tb/tb_m8088_bus_target.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m8088_bus_pkg.sv
// Shared types and constants for the 8088 bus target.
package m8088_bus_pkg;

  localparam int         ADDR_W      = 20;
  localparam int         WAIT_W      = 4;
  localparam logic [7:0] DIN_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_REQ  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } bus_state_t;

endpackage

// File: rtl/m8088_wait_counter.sv
// Loadable down-counter that saturates at zero; sets the minimum READY-low time.
module m8088_wait_counter
  import m8088_bus_pkg::*;
(
  input  logic              CORE_CLK,
  input  logic              RESET_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge CORE_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/m8088_bus_target.sv
// 8088 bus target: turns CPU bus cycles into a req/ack backend handshake.
// Optional interrupt-acknowledge handling is enabled by M8088_TARGET_INTA_EN.
module m8088_bus_target
  import m8088_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic              CORE_CLK,
  input  logic              RESET_n,
  input  logic              ALE,
  input  logic              RD_n,
  input  logic              WR_n,
  input  logic              INTA_n,
  input  logic              IOM,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        dout,
  output logic [7:0]        din,
  output logic              READY,
  output logic              req,
  output logic              req_we,
  output logic              req_io,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_wdata,
  input  logic              ack,
  input  logic [7:0]        rdata,
  input  logic [7:0]        int_vector,
  output logic [2:0]        state_dbg
);

  // Backend handshake: req rises with addr/we/io/wdata valid and holds all of
  // them stable until ack is sampled high; req drops the cycle after. ack is
  // ignored whenever req is low.

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  bus_state_t        state, state_nxt;
  logic              ale_q, ale_q_nxt;
  logic              abort_q, abort_nxt;
  logic              aborting;
  logic              inta_strobe;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [7:0]        din_nxt;
  logic              ready_nxt, req_nxt, req_we_nxt, req_io_nxt;
  logic [ADDR_W-1:0] req_addr_nxt;
  logic [7:0]        req_wdata_nxt;

  assign state_dbg = state;
  assign cnt_load  = (state == S_ADDR) && (state_nxt == S_REQ);
  assign cnt_dec   = (state == S_REQ) || (state == S_HOLD);
  // A released strobe during REQ still finishes the backend transfer.
  assign aborting  = abort_q || ((state == S_REQ) && RD_n && WR_n);

  m8088_wait_counter u_wait (
    .CORE_CLK (CORE_CLK),
    .RESET_n  (RESET_n),
    .load     (cnt_load),
    .load_val (WAIT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef M8088_TARGET_INTA_EN
  logic inta_cnt, inta_cnt_nxt;

  assign inta_strobe = !INTA_n;

  always_ff @(posedge CORE_CLK or negedge RESET_n) begin
    if (!RESET_n) inta_cnt <= 1'b0;
    else          inta_cnt <= inta_cnt_nxt;
  end
`else
  logic unused_int_vector;

  assign inta_strobe       = 1'b0;
  assign unused_int_vector = ^int_vector;
`endif

  always_ff @(posedge CORE_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= S_IDLE;
      ale_q     <= 1'b0;
      abort_q   <= 1'b0;
      din       <= DIN_DEFAULT;
      READY     <= 1'b1;
      req       <= 1'b0;
      req_we    <= 1'b0;
      req_io    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      state     <= state_nxt;
      ale_q     <= ale_q_nxt;
      abort_q   <= abort_nxt;
      din       <= din_nxt;
      READY     <= ready_nxt;
      req       <= req_nxt;
      req_we    <= req_we_nxt;
      req_io    <= req_io_nxt;
      req_addr  <= req_addr_nxt;
      req_wdata <= req_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (inta_strobe)        state_nxt = S_DONE;
        else if (!ALE && ale_q) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (!WR_n || !RD_n)     state_nxt = S_REQ;
        else if (inta_strobe)   state_nxt = S_DONE;
        else if (ALE)           state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (ack) begin
          if (!cnt_zero)        state_nxt = S_HOLD;
          else if (aborting)    state_nxt = S_IDLE;
          else                  state_nxt = S_DONE;
        end
      end
      S_HOLD: begin
        if (cnt_zero)           state_nxt = aborting ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (RD_n && WR_n && INTA_n) state_nxt = S_IDLE;
      end
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ale_q_nxt     = 1'b0;
    abort_nxt     = abort_q;
    din_nxt       = din;
    req_we_nxt    = req_we;
    req_io_nxt    = req_io;
    req_addr_nxt  = req_addr;
    req_wdata_nxt = req_wdata;
    ready_nxt     = (state_nxt == S_IDLE) || (state_nxt == S_DONE);
    req_nxt       = (state_nxt == S_REQ);

    // Address is only ever taken in IDLE; ALE elsewhere is ignored.
    if (state == S_IDLE) begin
      ale_q_nxt = ALE;
      if (ALE) begin
        req_addr_nxt = addr;
        req_io_nxt   = IOM;
      end
    end

    // WR_n wins when both strobes are low.
    if (cnt_load) begin
      req_we_nxt = !WR_n;
      abort_nxt  = 1'b0;
      if (!WR_n) req_wdata_nxt = dout;
    end

    if (state == S_REQ) begin
      if (RD_n && WR_n) abort_nxt = 1'b1;
      if (ack)          din_nxt   = rdata;
    end

`ifdef M8088_TARGET_INTA_EN
    inta_cnt_nxt = inta_cnt;
    if (((state == S_IDLE) || (state == S_ADDR)) && (state_nxt == S_DONE)) begin
      din_nxt      = inta_cnt ? int_vector : DIN_DEFAULT;
      inta_cnt_nxt = !inta_cnt;
    end
`endif
  end

endmodule

// File: tb/tb_m8088_bus_target.sv
// Bench for m8088_bus_target: two instances (WAIT_STATES 1 and 4) on one shared bus.
module tb_m8088_bus_target;
  import m8088_bus_pkg::*;

  localparam logic [2:0] ST_IDLE = 3'(S_IDLE);
  localparam logic [2:0] ST_DONE = 3'(S_DONE);
  localparam int WS0 = 1;
  localparam int WS1 = 4;

  logic CORE_CLK = 1'b0;
  always #5 CORE_CLK = ~CORE_CLK;

  logic RESET_n, ALE, RD_n, WR_n, INTA_n, IOM, ack;
  logic [19:0] addr;
  logic [7:0]  dout, rdata, int_vector;

  logic [1:0][7:0]  din;
  logic [1:0]       ready, req, req_we, req_io;
  logic [1:0][19:0] req_addr;
  logic [1:0][7:0]  req_wdata;
  logic [1:0][2:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int rises0  = 0;
  int rises1  = 0;
  logic [1:0] req_q = 2'b00;
  logic [7:0] last_din;

  m8088_bus_target #(.WAIT_STATES(WS0)) u_dut0 (
    .CORE_CLK(CORE_CLK), .RESET_n(RESET_n), .ALE(ALE), .RD_n(RD_n), .WR_n(WR_n),
    .INTA_n(INTA_n), .IOM(IOM), .addr(addr), .dout(dout), .din(din[0]), .READY(ready[0]),
    .req(req[0]), .req_we(req_we[0]), .req_io(req_io[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .ack(ack), .rdata(rdata), .int_vector(int_vector),
    .state_dbg(state_dbg[0])
  );

  m8088_bus_target #(.WAIT_STATES(WS1)) u_dut1 (
    .CORE_CLK(CORE_CLK), .RESET_n(RESET_n), .ALE(ALE), .RD_n(RD_n), .WR_n(WR_n),
    .INTA_n(INTA_n), .IOM(IOM), .addr(addr), .dout(dout), .din(din[1]), .READY(ready[1]),
    .req(req[1]), .req_we(req_we[1]), .req_io(req_io[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .ack(ack), .rdata(rdata), .int_vector(int_vector),
    .state_dbg(state_dbg[1])
  );

  // Handshake counter: each req rising edge is one backend request.
  always @(negedge CORE_CLK) begin
    if (req[0] && !req_q[0]) rises0++;
    if (req[1] && !req_q[1]) rises1++;
    req_q = req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    int          strobe;   // 0 read, 1 write, 2 both strobes
    logic        io;
    logic [19:0] a;
    logic [7:0]  wd;
    logic [7:0]  rd;
    int          lat;
    logic        ab;
    logic [19:0] e_addr;
    logic        e_io;
    logic        e_we;
    logic [7:0]  e_wdata;
    logic [7:0]  e_din;
    int          e_low0;
    int          e_low1;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge CORE_CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: READY stays low max(ack latency+1, WAIT_STATES+1) cycles after strobe.
  function automatic int exp_low(input int lat, input int ws);
    return (lat + 1 > ws + 1) ? lat + 1 : ws + 1;
  endfunction

  task automatic bus_txn(input vec_t v, input string tag);
    int   low0, low1, r0, r1;
    bit   d0, d1, stable;
    low0 = 0; low1 = 0; d0 = 0; d1 = 0; stable = 1;
    r0 = rises0; r1 = rises1;
    ALE = 1; addr = v.a; IOM = v.io;
    tick();
    ALE = 0; addr = 20'($urandom); IOM = ~v.io;
    RD_n = !((v.strobe == 0) || (v.strobe == 2));
    WR_n = !((v.strobe == 1) || (v.strobe == 2));
    dout = v.wd;
    tick();
    check({tag, " ready_addr"}, 64'(ready), 64'(2'b00));
    tick();
    dout = ~v.wd;
    check({tag, " req_on"}, 64'(req), 64'(2'b11));
    check({tag, " req_addr"}, 64'(req_addr), 64'({v.e_addr, v.e_addr}));
    check({tag, " req_io"}, 64'(req_io), 64'({v.e_io, v.e_io}));
    check({tag, " req_we"}, 64'(req_we), 64'({v.e_we, v.e_we}));
    if (v.e_we) check({tag, " req_wdata"}, 64'(req_wdata), 64'({v.e_wdata, v.e_wdata}));
    for (int k = 1; k <= 40; k++) begin
      if (!d0) begin if (ready[0]) d0 = 1; else low0++; end
      if (!d1) begin if (ready[1]) d1 = 1; else low1++; end
      if ((k <= v.lat + 1) && ((req !== 2'b11) || (req_addr !== {v.e_addr, v.e_addr}))) stable = 0;
      if (k == v.lat + 2) check({tag, " req_drop"}, 64'(req), 64'(2'b00));
      if (d0 && d1) break;
      ack   = (k == v.lat + 1);
      rdata = ack ? v.rd : ~v.rd;
      ALE   = (k == 1);
      if (k == 1) addr = 20'($urandom);
      if (v.ab && (k == 1)) begin RD_n = 1; WR_n = 1; end
      tick();
    end
    ack = 0; ALE = 0;
    check({tag, " req_stable"}, 64'(stable), 64'(1));
    check({tag, " low_ws1"}, 64'(low0), 64'(v.e_low0));
    check({tag, " low_ws4"}, 64'(low1), 64'(v.e_low1));
    check({tag, " din"}, 64'(din), 64'({v.e_din, v.e_din}));
    check({tag, " handshakes"}, 64'({rises0 - r0, rises1 - r1}), 64'({32'd1, 32'd1}));
    if (v.ab) begin
      check({tag, " abort_idle"}, 64'(state_dbg), 64'({ST_IDLE, ST_IDLE}));
    end else begin
      check({tag, " done_state"}, 64'(state_dbg), 64'({ST_DONE, ST_DONE}));
      RD_n = 1; WR_n = 1;
      tick();
      check({tag, " back_idle"}, 64'(state_dbg), 64'({ST_IDLE, ST_IDLE}));
    end
    check({tag, " ready_end"}, 64'(ready), 64'(2'b11));
    RD_n = 1; WR_n = 1;
    last_din = v.e_din;
  endtask

  task automatic inta_pulse(input logic [7:0] exp_din, input string tag);
    int r0, r1;
    r0 = rises0; r1 = rises1;
    INTA_n = 0;
    tick();
    check({tag, " ready_low_strobe"}, 64'(ready), 64'(2'b11));
    int_vector = 8'h55;
    tick();
    INTA_n = 1;
    tick();
    check({tag, " state"}, 64'(state_dbg), 64'({ST_IDLE, ST_IDLE}));
    check({tag, " din"}, 64'(din), 64'({exp_din, exp_din}));
    check({tag, " no_req"}, 64'({rises0 - r0, rises1 - r1, req}), 64'(0));
    int_vector = 8'h08;
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{0, 1'b0, 20'h12345, 8'h00, 8'hA5, 1, 1'b0, 20'h12345, 1'b0, 1'b0, 8'h00, 8'hA5, 2, 5};
    vecs[1] = '{1, 1'b1, 20'h00060, 8'h3C, 8'h5A, 0, 1'b0, 20'h00060, 1'b1, 1'b1, 8'h3C, 8'h5A, 2, 5};
    vecs[2] = '{0, 1'b0, 20'hFFFFF, 8'h00, 8'h00, 0, 1'b0, 20'hFFFFF, 1'b0, 1'b0, 8'h00, 8'h00, 2, 5};
    vecs[3] = '{0, 1'b1, 20'h00000, 8'h00, 8'hC3, 6, 1'b0, 20'h00000, 1'b1, 1'b0, 8'h00, 8'hC3, 7, 7};
    vecs[4] = '{2, 1'b0, 20'hABCDE, 8'h99, 8'h11, 2, 1'b0, 20'hABCDE, 1'b0, 1'b1, 8'h99, 8'h11, 3, 5};
    vecs[5] = '{0, 1'b0, 20'h54321, 8'h00, 8'h77, 2, 1'b1, 20'h54321, 1'b0, 1'b0, 8'h00, 8'h77, 3, 5};

    RESET_n = 0; ALE = 0; RD_n = 1; WR_n = 1; INTA_n = 1; IOM = 0; ack = 0;
    addr = '0; dout = '0; rdata = '0; int_vector = 8'h08; last_din = 8'hFF;
    tick(); tick();
    check("rst ready", 64'(ready), 64'(2'b11));
    check("rst req", 64'({req, req_we, req_io}), 64'(0));
    check("rst req_addr", 64'(req_addr), 64'(0));
    check("rst req_wdata", 64'(req_wdata), 64'(0));
    check("rst din", 64'(din), 64'(16'hFFFF));
    check("rst state", 64'(state_dbg), 64'({ST_IDLE, ST_IDLE}));
    RESET_n = 1;
    tick();

    for (int i = 0; i < 6; i++) bus_txn(vecs[i], $sformatf("vec%0d", i));

`ifdef M8088_TARGET_INTA_EN
    inta_pulse(8'hFF, "inta1");
    inta_pulse(8'h08, "inta2");
`else
    inta_pulse(last_din, "inta1");
    inta_pulse(last_din, "inta2");
`endif

    // Cycle dropped in ADDR by a fresh ALE; the new address must not be taken there.
    ALE = 1; addr = 20'h11111; IOM = 0;
    tick();
    ALE = 0;
    tick();
    check("drop addr_state", 64'(ready), 64'(2'b00));
    ALE = 1; addr = 20'h22222; IOM = 1;
    tick();
    check("drop ready", 64'(ready), 64'(2'b11));
    check("drop state", 64'(state_dbg), 64'({ST_IDLE, ST_IDLE}));
    check("drop no_latch", 64'(req_addr), 64'({20'h11111, 20'h11111}));
    ALE = 0;
    tick();
    check("drop stay_idle", 64'(state_dbg), 64'({ST_IDLE, ST_IDLE}));
    bus_txn('{0, 1'b1, 20'h22222, 8'h00, 8'h3E, 3, 1'b0, 20'h22222, 1'b1, 1'b0, 8'h00, 8'h3E,
              exp_low(3, WS0), exp_low(3, WS1)}, "after_drop");

    for (int i = 0; i < 20; i++) begin
      rv.strobe = $urandom_range(0, 2);
      rv.io     = 1'($urandom_range(0, 1));
      rv.a      = 20'($urandom);
      rv.wd     = 8'($urandom);
      rv.rd     = 8'($urandom);
      rv.lat    = $urandom_range(0, 7);
      rv.ab     = ($urandom_range(0, 7) == 0);
      rv.e_addr = rv.a;
      rv.e_io   = rv.io;
      rv.e_we   = (rv.strobe != 0);
      rv.e_wdata = rv.wd;
      rv.e_din  = rv.rd;
      rv.e_low0 = exp_low(rv.lat, WS0);
      rv.e_low1 = exp_low(rv.lat, WS1);
      bus_txn(rv, $sformatf("rnd%0d", i));
    end

    // Reset while REQ waits on a stalled ack; the late ack must be ignored.
    ALE = 1; addr = 20'h0ABCD; IOM = 0;
    tick();
    ALE = 0; RD_n = 0;
    tick(); tick();
    check("rstmid req_on", 64'(req), 64'(2'b11));
    tick(); tick();
    #2 RESET_n = 0;
    #1;
    check("rstmid ready", 64'(ready), 64'(2'b11));
    check("rstmid req", 64'(req), 64'(2'b00));
    check("rstmid din", 64'(din), 64'(16'hFFFF));
    check("rstmid state", 64'(state_dbg), 64'({ST_IDLE, ST_IDLE}));
    tick();
    RESET_n = 1; RD_n = 1;
    tick();
    ack = 1; rdata = 8'h3A;
    tick();
    ack = 0;
    tick();
    check("late_ack req", 64'({req, req_we, req_io}), 64'(0));
    check("late_ack ready", 64'(ready), 64'(2'b11));
    check("late_ack din", 64'(din), 64'(16'hFFFF));
    check("late_ack state", 64'(state_dbg), 64'({ST_IDLE, ST_IDLE}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
